// File: rtl/pll_dri_pkg.sv
// rtl/pll_dri_pkg.sv - shared types and constants for the PLL DRI controller
package pll_dri_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_RELOCK,
      ST_RESP
   } state_t;

   localparam logic [1:0] ERR_OK   = 2'd0;
   localparam logic [1:0] ERR_ACK  = 2'd1;
   localparam logic [1:0] ERR_LOCK = 2'd2;

   localparam int CTRL_STB_BIT  = 10;
   localparam int CTRL_WR_BIT   = 9;
   localparam int CTRL_ADDR_MSB = 8;
   localparam int CTRL_ADDR_LSB = 0;

   // Builds the DRI control word for a strobed access
   function automatic logic [10:0] dri_ctrl_word(input logic wr, input logic [8:0] addr);
      logic [10:0] w;
      w = '0;
      w[CTRL_STB_BIT] = 1'b1;
      w[CTRL_WR_BIT]  = wr;
      w[CTRL_ADDR_MSB:CTRL_ADDR_LSB] = addr;
      return w;
   endfunction

endpackage

// File: rtl/lock_sync.sv
// rtl/lock_sync.sv - PLL lock synchroniser and consecutive-lock counter
module lock_sync #(
   parameter int LOCK_STABLE = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_pll_lock,
   input  logic i_en,
   output logic o_locked_stable
);

   localparam int SW = $clog2(LOCK_STABLE) + 1;
   localparam logic [SW-1:0] C_STABLE = SW'(LOCK_STABLE);

   logic          r_sync1;
   logic          r_sync2;
   logic [SW-1:0] r_stable_cnt;

   // Two-flop synchroniser; the count only runs while enabled so each relock starts from zero
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1      <= 1'b0;
         r_sync2      <= 1'b0;
         r_stable_cnt <= '0;
      end else begin
         r_sync1 <= i_pll_lock;
         r_sync2 <= r_sync1;
         if (!i_en || !r_sync2) begin
            r_stable_cnt <= '0;
         end else if (r_stable_cnt != C_STABLE) begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
         end
      end
   end

   assign o_locked_stable = (r_stable_cnt == C_STABLE);

endmodule

// File: rtl/pll_dri_ctrl.sv
// rtl/pll_dri_ctrl.sv - single-command DRI access sequencer with optional PLL relock wait
module pll_dri_ctrl #(
   parameter int ACK_TIMEOUT  = 255,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int LOCK_STABLE  = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_write,
   input  logic        i_cmd_relock,
   input  logic [8:0]  i_cmd_addr,
   input  logic [31:0] i_cmd_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic [1:0]  o_rsp_error,
   output logic [10:0] o_dri_ctrl,
   output logic [32:0] o_dri_wdata,
   input  logic [32:0] i_dri_rdata,
   output logic        o_dri_arst_n,
   input  logic        i_pll_lock,
   output logic        o_busy
);

   import pll_dri_pkg::*;

   localparam int AW = $clog2(ACK_TIMEOUT) + 1;
   localparam int LW = $clog2(LOCK_TIMEOUT) + 1;
   localparam logic [AW-1:0] C_ACK_LAST  = AW'(ACK_TIMEOUT - 1);
   localparam logic [LW-1:0] C_LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

   state_t        r_state;
   state_t        w_next;
   logic          r_we;
   logic          r_relock;
   logic [8:0]    r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic [1:0]    r_err;
   logic [AW-1:0] r_ack_cnt;
   logic [LW-1:0] r_lock_cnt;
   logic          r_reset_q;
   logic          w_done;
   logic          w_ack_last;
   logic          w_lock_last;
   logic          w_locked_stable;
   logic          w_relock_en;

   assign w_done      = i_dri_rdata[32];
   assign w_ack_last  = (r_ack_cnt == C_ACK_LAST);
   assign w_lock_last = (r_lock_cnt == C_LOCK_LAST);
   assign w_relock_en = (r_state == ST_RELOCK);

   lock_sync #(
      .LOCK_STABLE (LOCK_STABLE)
   ) u_lock_sync (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_pll_lock      (i_pll_lock),
      .i_en            (w_relock_en),
      .o_locked_stable (w_locked_stable)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_next      = r_state;
      o_cmd_ready = 1'b0;
      o_busy      = 1'b1;
      o_rsp_valid = 1'b0;
      o_dri_ctrl  = '0;
      o_dri_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            o_cmd_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_cmd_valid) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            o_dri_ctrl  = dri_ctrl_word(r_we, r_addr);
            o_dri_wdata = {1'b0, r_wdata};
            w_next      = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (w_done)          w_next = (r_we && r_relock) ? ST_RELOCK : ST_RESP;
            else if (w_ack_last) w_next = ST_RESP;
         end
         ST_RELOCK: begin
            if (w_locked_stable || w_lock_last) w_next = ST_RESP;
         end
         ST_RESP: begin
            o_rsp_valid = 1'b1;
            w_next      = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Command latch, response capture and wait counters
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_we       <= 1'b0;
         r_relock   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_err      <= ERR_OK;
         r_ack_cnt  <= '0;
         r_lock_cnt <= '0;
      end else begin
         if (r_state == ST_IDLE && i_cmd_valid) begin
            r_we     <= i_cmd_write;
            r_relock <= i_cmd_relock;
            r_addr   <= i_cmd_addr;
            r_wdata  <= i_cmd_wdata;
            r_rdata  <= '0;
            r_err    <= ERR_OK;
         end
         if (r_state == ST_WAIT_ACK) begin
            if (w_done) begin
               if (!r_we) r_rdata <= i_dri_rdata[31:0];
            end else if (w_ack_last) begin
               r_err <= ERR_ACK;
            end
         end
         // Stable lock wins over a simultaneous timeout
         if (r_state == ST_RELOCK && !w_locked_stable && w_lock_last) r_err <= ERR_LOCK;
         if (r_state != ST_WAIT_ACK)     r_ack_cnt <= '0;
         else if (r_ack_cnt != C_ACK_LAST) r_ack_cnt <= r_ack_cnt + 1'b1;
         if (r_state != ST_RELOCK)        r_lock_cnt <= '0;
         else if (r_lock_cnt != C_LOCK_LAST) r_lock_cnt <= r_lock_cnt + 1'b1;
      end
   end

   // Registered copy of reset drives the DRI reset
   always_ff @(posedge i_clk) begin
      r_reset_q <= i_reset;
   end

   assign o_dri_arst_n = ~r_reset_q;
   assign o_rsp_rdata  = r_rdata;
   assign o_rsp_error  = r_err;

endmodule

// File: tb/tb_pll_dri_ctrl.sv
// tb/tb_pll_dri_ctrl.sv - randomized and directed self-checking bench for pll_dri_ctrl
module tb_pll_dri_ctrl;

   localparam int AT = 8;
   localparam int LT = 100;
   localparam int LS = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_relock;
   logic [8:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_error;
   logic [10:0] dri_ctrl;
   logic [32:0] dri_wdata;
   logic [32:0] dri_rdata;
   logic        dri_arst_n;
   logic        pll_lock;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic pll_wave [0:255];
   int   done_at;
   logic spur;

   pll_dri_ctrl #(
      .ACK_TIMEOUT  (AT),
      .LOCK_TIMEOUT (LT),
      .LOCK_STABLE  (LS)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_write  (cmd_write),
      .i_cmd_relock (cmd_relock),
      .i_cmd_addr   (cmd_addr),
      .i_cmd_wdata  (cmd_wdata),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_error  (rsp_error),
      .o_dri_ctrl   (dri_ctrl),
      .o_dri_wdata  (dri_wdata),
      .i_dri_rdata  (dri_rdata),
      .o_dri_arst_n (dri_arst_n),
      .i_pll_lock   (pll_lock),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic fill_wave(input int lo_until, input int glitch);
      for (int i = 0; i < 256; i++) pll_wave[i] = (i >= lo_until) && (i != glitch);
   endtask

   // Cycle numbers are relative to the accept cycle (0): ISSUE is 1, waiting starts at 2.
   // A lock sample taken in cycle j is visible to the controller two cycles later.
   task automatic model(input logic we, input logic relock, input logic [31:0] rd,
                        output int rc, output int err, output logic [31:0] rdata);
      int d;
      int e;
      int run;
      d = -1;
      for (int c = 2; c < 2 + AT; c++) if (c == done_at && d < 0) d = c;
      if (d < 0) begin
         rc = 2 + AT; err = 1; rdata = 32'h0;
         return;
      end
      rdata = we ? 32'h0 : rd;
      err   = 0;
      if (!(we && relock)) begin
         rc = d + 1;
         return;
      end
      e   = d + 1;
      run = 0;
      rc  = -1;
      for (int c = e; c < 250 && rc < 0; c++) begin
         if (run >= LS)           begin rc = c + 1; err = 0; end
         else if (c - e >= LT - 1) begin rc = c + 1; err = 2; end
         else run = pll_wave[c - 2] ? run + 1 : 0;
      end
   endtask

   task automatic run_cmd(input string name, input logic we, input logic relock,
                          input logic [8:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, output int rc_o);
      int rc_e, err_e, n_rsp, n_stb, n_busy;
      logic [31:0] rdat_e, rdat_o;
      logic [1:0]  err_o;
      logic [10:0] ctrl1;
      logic [32:0] wd1;
      logic        busy_after, ready_after;
      model(we, relock, rd, rc_e, err_e, rdat_e);
      rc_o = -1; n_rsp = 0; n_stb = 0; n_busy = 0;
      rdat_o = '0; err_o = '0; ctrl1 = '0; wd1 = '0;
      busy_after = 1'b1; ready_after = 1'b0;
      cmd_valid = 1'b1; cmd_write = we; cmd_relock = relock;
      cmd_addr = addr; cmd_wdata = wd;
      pll_lock = pll_wave[0];
      dri_rdata = {1'b0, $urandom()};
      for (int c = 0; c <= rc_e + 1 && c < 250; c++) begin
         @(negedge clk);
         if (c == 0) chk({name, ".ready"}, cmd_ready, 1);
         if (dri_ctrl != '0) n_stb++;
         if (busy && c >= 1 && c <= rc_e) n_busy++;
         if (c == 1) begin ctrl1 = dri_ctrl; wd1 = dri_wdata; end
         if (rsp_valid) begin
            n_rsp++;
            if (rc_o < 0) begin rc_o = c; err_o = rsp_error; rdat_o = rsp_rdata; end
         end
         if (c == rc_e + 1) begin busy_after = busy; ready_after = cmd_ready; end
         @(posedge clk);
         #1;
         cmd_valid  = (c + 1 <= rc_e) ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_write  = 1'($urandom_range(0, 1));
         cmd_relock = 1'($urandom_range(0, 1));
         cmd_addr   = 9'($urandom());
         cmd_wdata  = $urandom();
         pll_lock   = pll_wave[(c + 1 > 255) ? 255 : c + 1];
         dri_rdata  = {((c + 1) == done_at) || (spur && (c + 1) == 1),
                       ((c + 1) == done_at) ? rd : $urandom()};
      end
      cmd_valid = 1'b0;
      dri_rdata = '0;
      chk({name, ".rsp_cycle"}, rc_o, rc_e);
      chk({name, ".rsp_count"}, n_rsp, 1);
      chk({name, ".rsp_error"}, err_o, err_e);
      chk({name, ".rsp_rdata"}, rdat_o, rdat_e);
      chk({name, ".strobes"}, n_stb, 1);
      chk({name, ".ctrl"}, ctrl1, {1'b1, we, addr});
      chk({name, ".wdata"}, wd1, {1'b0, wd});
      chk({name, ".busy_cycles"}, n_busy, rc_e);
      chk({name, ".busy_after"}, busy_after, 0);
      chk({name, ".ready_after"}, ready_after, 1);
   endtask

   initial begin
      int rc;
      int n_rv;
      int hi_from;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_relock = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; dri_rdata = '0; pll_lock = 1'b0;
      done_at = -1; spur = 1'b0;
      fill_wave(0, -1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.arst_n_low", dri_arst_n, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst.ready", cmd_ready, 1);
      chk("rst.busy", busy, 0);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.rsp_rdata", rsp_rdata, 0);
      chk("rst.rsp_error", rsp_error, 0);
      chk("rst.dri_ctrl", dri_ctrl, 0);
      chk("rst.dri_wdata", dri_wdata, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst.arst_n_high", dri_arst_n, 1);
      @(posedge clk); #1;

      done_at = 3; spur = 1'b0; fill_wave(0, -1);
      run_cmd("wr_basic", 1'b1, 1'b0, 9'h012, 32'h0000_006D, 32'h0, rc);
      chk("wr_basic.latency", rc, 4);

      done_at = 2;
      run_cmd("rd_basic", 1'b0, 1'b0, 9'h005, 32'h0, 32'hA5A5_0001, rc);

      done_at = -1;
      run_cmd("ack_timeout", 1'b0, 1'b0, 9'h0F0, 32'h1234_5678, 32'h0, rc);
      chk("ack_timeout.latency", rc, 2 + AT);

      done_at = 2; fill_wave(23, 28);
      run_cmd("relock_glitch", 1'b1, 1'b1, 9'h100, 32'hDEAD_BEEF, 32'h0, rc);
      chk("relock_glitch.latency", rc, 48);

      done_at = 4; fill_wave(256, -1);
      run_cmd("lock_timeout", 1'b1, 1'b1, 9'h033, 32'h0000_0001, 32'h0, rc);
      chk("lock_timeout.latency", rc, 5 + LT);

      // Reset in the middle of an ack wait
      done_at = -1; n_rv = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_relock = 1'b0; cmd_addr = 9'h0AA;
      @(posedge clk); #1; cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); if (rsp_valid) n_rv++;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk); if (rsp_valid) n_rv++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst.ready", cmd_ready, 1);
      chk("mid_rst.busy", busy, 0);
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) n_rv++;
         @(negedge clk);
      end
      chk("mid_rst.no_rsp", n_rv, 0);
      @(posedge clk); #1;
      done_at = 2; fill_wave(0, -1);
      run_cmd("after_rst", 1'b1, 1'b0, 9'h1FF, 32'hCAFE_F00D, 32'h0, rc);

      for (int t = 0; t < 40; t++) begin
         done_at = $urandom_range(1, 11);
         spur    = 1'($urandom_range(0, 1));
         hi_from = ($urandom_range(0, 4) == 0) ? 256 : $urandom_range(0, 60);
         fill_wave(hi_from, ($urandom_range(0, 1) == 1) ? hi_from + $urandom_range(1, 20) : -1);
         run_cmd($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 9'($urandom()), $urandom(), $urandom(), rc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
